cacheline_arbiter: RTL

//  Two-client arbiter upstream of the cacheline adaptor. Muxes I-cache (read-only) and D-cache
//  (read/write) 256-bit line miss/writeback requests onto the single LLC-side adaptor port.

---
 rtl/cacheline_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cacheline_arbiter.sv
// Purpose: two-client (I-cache / D-cache) arbiter in front of the single cacheline adaptor port.
// Latency: request seen in IDLE -> mem_read/mem_write next cycle; mem_resp -> client resp next cycle.
// Backpressure: one transaction at a time; losing client holds its request until it is granted.
module cacheline_arbiter #(
    parameter bit          D_PRIORITY = 1'b1,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [255:0] mem_line_o,
    input  logic [255:0] mem_line_i,
    output logic [31:0]  mem_address,
    output logic         mem_read,
    output logic         mem_write,
    input  logic         mem_resp,
    output logic         err_o
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
    // The counter holds the number of grant cycles including the current one.
    localparam logic [CW-1:0] CNT_START = (TIMEOUT > 0) ? CW'(1) : '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t        state;
    logic          last_grant_d;   // winner of the most recent tie: 1 = D, 0 = I
    logic          op_write;       // registered op of the current D grant
    logic [CW-1:0] cnt;

    logic d_req;
    logic tie;
    logic pick_d;

    // Arbitration decision for the current IDLE cycle.
    always_comb begin
        d_req  = d_read | d_write;
        tie    = i_read & d_req;
        pick_d = 1'b0;
        if (d_req && !i_read) begin
            pick_d = 1'b1;
        end else if (tie) begin
            pick_d = D_PRIORITY ? 1'b1 : ~last_grant_d;
        end
    end

    // Arbiter FSM with registered adaptor-side and client-side outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            op_write     <= 1'b0;
            cnt          <= '0;
            err_o        <= 1'b0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_line_o   <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_read || d_req) begin
                        cnt <= CNT_START;
                        if (tie) begin
                            last_grant_d <= pick_d;
                        end
                        if (pick_d) begin
                            // Read+write together is treated as a writeback.
                            state       <= GRANT_D;
                            mem_address <= d_address;
                            mem_line_o  <= d_wdata;
                            op_write    <= d_write;
                            mem_read    <= ~d_write;
                            mem_write   <= d_write;
                        end else begin
                            state       <= GRANT_I;
                            mem_address <= i_address;
                            op_write    <= 1'b0;
                            mem_read    <= 1'b1;
                            mem_write   <= 1'b0;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (state == GRANT_I) begin
                            state   <= RESP_I;
                            i_resp  <= 1'b1;
                            i_rdata <= mem_line_i;
                        end else begin
                            state  <= RESP_D;
                            d_resp <= 1'b1;
                            if (!op_write) begin
                                d_rdata <= mem_line_i;
                            end
                        end
                    end else if (TIMEOUT != 0) begin
                        // Flag only; the grant keeps waiting for the adaptor.
                        if (cnt == CNT_MAX) begin
                            err_o <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP_I, RESP_D: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
